// File: rtl/seg_595_pkg.sv
// Shared definitions for the 74HC595 display link: field widths, frame bit order
// and helpers for decoding a captured shift-register word.
package seg_595_pkg;

    localparam int SEL_W   = 6;
    localparam int SEG_W   = 8;
    localparam int BIT_NUM = SEL_W + SEG_W;

    // After a full frame, sel[k] sits at SR_SEL0_POS-k and seg[j] at SR_SEG0_POS+j.
    localparam int SR_SEL0_POS = BIT_NUM - 1;
    localparam int SR_SEG0_POS = 0;

    typedef logic [BIT_NUM-1:0] frame_sr_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SEG_W-1:0] seg;
    } frame_t;

    function automatic frame_t unpack_frame(input frame_sr_t sr);
        frame_t f;
        for (int k = 0; k < SEL_W; k++) f.sel[k] = sr[SR_SEL0_POS-k];
        for (int j = 0; j < SEG_W; j++) f.seg[j] = sr[SR_SEG0_POS+j];
        return f;
    endfunction

    function automatic logic is_onehot(input logic [SEL_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one link pin, with a delayed copy and a registered
// rise pulse that are aligned with each other.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync_o,
    output logic dly_o,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              dly_q, dly_d;
    logic              rise_q, rise_d;

    // dly_o lags sync_o by one cycle so it lines up with rise_o for data capture.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
        dly_d   = chain_q[STAGES-1];
        rise_d  = chain_q[STAGES-1] & ~dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            dly_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            dly_q   <= dly_d;
            rise_q  <= rise_d;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign dly_o  = dly_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/seg_595_rx.sv
// Receiver/monitor for the 74HC595 display link: oversamples the pins, rebuilds
// the shift/latch behaviour of the 595 pair and keeps a six-digit segment image.
module seg_595_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int BIT_NUM     = seg_595_pkg::BIT_NUM
) (
    input  logic                                            sys_clk,
    input  logic                                            sys_rst_n,
    input  logic                                            stcp,
    input  logic                                            shcp,
    input  logic                                            ds,
    input  logic                                            oe,
    output logic [seg_595_pkg::SEL_W-1:0]                   sel_out,
    output logic [seg_595_pkg::SEG_W-1:0]                   seg_out,
    output logic                                            disp_on,
    output logic                                            frame_valid,
    output logic                                            frame_err,
    output logic                                            onehot_err,
    output logic [seg_595_pkg::SEL_W*seg_595_pkg::SEG_W-1:0] digit_seg
);
    import seg_595_pkg::*;

    localparam int         SR_W     = $bits(frame_sr_t);
    localparam logic [3:0] CNT_MAX  = 4'd15;
    localparam logic [3:0] CNT_FULL = 4'(BIT_NUM);

    logic stcp_rise, shcp_rise, ds_dly, oe_sync;
    logic stcp_sync_unused, stcp_dly_unused, shcp_sync_unused, shcp_dly_unused;
    logic ds_sync_unused, ds_rise_unused, oe_dly_unused, oe_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(stcp),
        .sync_o(stcp_sync_unused), .dly_o(stcp_dly_unused), .rise_o(stcp_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(shcp),
        .sync_o(shcp_sync_unused), .dly_o(shcp_dly_unused), .rise_o(shcp_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(ds),
        .sync_o(ds_sync_unused), .dly_o(ds_dly), .rise_o(ds_rise_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(oe),
        .sync_o(oe_sync), .dly_o(oe_dly_unused), .rise_o(oe_rise_unused)
    );

    frame_sr_t                  sr_q, sr_d, sr_shift;
    logic [3:0]                 bit_cnt_q, bit_cnt_d, cnt_shift;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [SEG_W-1:0]           seg_q, seg_d;
    logic                       valid_q, valid_d;
    logic                       ferr_q, ferr_d;
    logic                       oherr_q, oherr_d;
    logic                       disp_q, disp_d;
    logic [SEL_W*SEG_W-1:0]     digit_q, digit_d;
    frame_t                     frame;

    // A coincident shift is applied first, so the latch sees the post-shift word and count.
    always_comb begin
        sr_shift  = sr_q;
        cnt_shift = bit_cnt_q;
        if (shcp_rise) begin
            sr_shift = {sr_q[SR_W-2:0], ds_dly};
            if (bit_cnt_q != CNT_MAX) cnt_shift = bit_cnt_q + 4'd1;
        end

        frame     = unpack_frame(sr_shift);
        sr_d      = sr_shift;
        bit_cnt_d = cnt_shift;
        sel_d     = sel_q;
        seg_d     = seg_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;
        oherr_d   = oherr_q;
        digit_d   = digit_q;
        disp_d    = ~oe_sync;

        if (stcp_rise) begin
            sel_d     = frame.sel;
            seg_d     = frame.seg;
            valid_d   = 1'b1;
            bit_cnt_d = 4'd0;
            if (cnt_shift != CNT_FULL) ferr_d = 1'b1;
            if (!is_onehot(frame.sel)) begin
                oherr_d = 1'b1;
            end else begin
                for (int i = 0; i < SEL_W; i++) begin
                    if (frame.sel[i]) digit_d[i*SEG_W +: SEG_W] = frame.seg;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            sel_q     <= '0;
            seg_q     <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            oherr_q   <= 1'b0;
            disp_q    <= 1'b0;
            digit_q   <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            oherr_q   <= oherr_d;
            disp_q    <= disp_d;
            digit_q   <= digit_d;
        end
    end

    assign sel_out     = sel_q;
    assign seg_out     = seg_q;
    assign frame_valid = valid_q;
    assign frame_err   = ferr_q;
    assign onehot_err  = oherr_q;
    assign disp_on     = disp_q;
    assign digit_seg   = digit_q;

endmodule

// File: tb/tb_seg_595_rx.sv
// Directed, table-driven bench for seg_595_rx: frames are bit-banged onto the link
// pins and the latched words, digit image, flags and frame_valid timing are checked.
module tb_seg_595_rx;

    localparam int SYNC_STAGES = 2;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        stcp, shcp, ds, oe;
    logic [5:0]  sel_out;
    logic [7:0]  seg_out;
    logic        disp_on, frame_valid, frame_err, onehot_err;
    logic [47:0] digit_seg;

    int n_vec  = 0;
    int n_fail = 0;

    seg_595_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe),
        .sel_out(sel_out), .seg_out(seg_out), .disp_on(disp_on),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .onehot_err(onehot_err), .digit_seg(digit_seg)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    typedef struct {
        logic [5:0]  sel;
        logic [7:0]  seg;
        int          nbits;
        bit          coincident;
        logic [5:0]  exp_sel;
        logic [7:0]  exp_seg;
        logic [47:0] exp_digits;
        bit          exp_ferr;
        bit          exp_oherr;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        ds = b;
        @(negedge sys_clk);
        shcp = 1'b1;
        repeat (2) @(negedge sys_clk);
        shcp = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    // Shifts bits sel[0]..sel[5], seg[7]..seg[0] (first nbits of them), then pulses stcp
    // while measuring frame_valid latency in sys_clk edges after stcp is first sampled.
    task automatic sendFrame(input logic [5:0] sel, input logic [7:0] seg, input int nbits,
                             input bit coincident, output int lat, output int pulses);
        logic [13:0] word;
        int          nshift;
        for (int k = 0; k < 6; k++) word[13-k] = sel[k];
        for (int j = 0; j < 8; j++) word[j] = seg[j];
        nshift = coincident ? nbits - 1 : nbits;
        for (int b = 0; b < nshift; b++) sendBit(word[13-b]);
        if (coincident) begin
            ds = word[13-nshift];
            @(negedge sys_clk);
            shcp = 1'b1;
        end
        stcp   = 1'b1;
        lat    = -1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (frame_valid) begin
                pulses++;
                if (lat < 0) lat = i - 1;
            end
            if (i == 3) begin
                stcp = 1'b0;
                shcp = 1'b0;
            end
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input int idx);
        int lat, pulses;
        vec_t v;
        v = vecs[idx];
        sendFrame(v.sel, v.seg, v.nbits, v.coincident, lat, pulses);
        checkOutput($sformatf("v%0d sel_out", idx), 48'(sel_out), 48'(v.exp_sel));
        checkOutput($sformatf("v%0d seg_out", idx), 48'(seg_out), 48'(v.exp_seg));
        checkOutput($sformatf("v%0d digit_seg", idx), digit_seg, v.exp_digits);
        checkOutput($sformatf("v%0d frame_err", idx), 48'(frame_err), 48'(v.exp_ferr));
        checkOutput($sformatf("v%0d onehot_err", idx), 48'(onehot_err), 48'(v.exp_oherr));
        checkOutput($sformatf("v%0d valid_latency", idx), 48'(lat), 48'(SYNC_STAGES + 1));
        checkOutput($sformatf("v%0d valid_pulses", idx), 48'(pulses), 48'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " sel_out"}, 48'(sel_out), 48'd0);
        checkOutput({tag, " seg_out"}, 48'(seg_out), 48'd0);
        checkOutput({tag, " digit_seg"}, digit_seg, 48'd0);
        checkOutput({tag, " frame_valid"}, 48'(frame_valid), 48'd0);
        checkOutput({tag, " frame_err"}, 48'(frame_err), 48'd0);
        checkOutput({tag, " onehot_err"}, 48'(onehot_err), 48'd0);
        checkOutput({tag, " disp_on"}, 48'(disp_on), 48'd0);
    endtask

    initial begin
        int lat, pulses;

        //            sel      seg    n  co  exp_sel  exp_seg  exp_digits            ferr oh
        vecs[0]  = '{6'h01, 8'hC0, 14, 0, 6'h01, 8'hC0, 48'h0000_0000_00C0, 0, 0};
        vecs[1]  = '{6'h01, 8'hF9, 14, 0, 6'h01, 8'hF9, 48'h0000_0000_00F9, 0, 0};
        vecs[2]  = '{6'h02, 8'hA4, 14, 0, 6'h02, 8'hA4, 48'h0000_0000_A4F9, 0, 0};
        vecs[3]  = '{6'h04, 8'hB0, 14, 0, 6'h04, 8'hB0, 48'h0000_00B0_A4F9, 0, 0};
        vecs[4]  = '{6'h08, 8'h99, 14, 0, 6'h08, 8'h99, 48'h0000_99B0_A4F9, 0, 0};
        vecs[5]  = '{6'h10, 8'h92, 14, 0, 6'h10, 8'h92, 48'h0092_99B0_A4F9, 0, 0};
        vecs[6]  = '{6'h20, 8'h82, 14, 0, 6'h20, 8'h82, 48'h8292_99B0_A4F9, 0, 0};
        vecs[7]  = '{6'h04, 8'h88, 14, 1, 6'h04, 8'h88, 48'h8292_9988_A4F9, 0, 0};
        vecs[8]  = '{6'h03, 8'h00, 14, 0, 6'h03, 8'h00, 48'h8292_9988_A4F9, 0, 1};
        // 13 bits: the oldest bit (0 from the previous word) lands in sel[0]
        vecs[9]  = '{6'h01, 8'hC0, 13, 0, 6'h02, 8'h60, 48'h8292_9988_60F9, 1, 1};
        vecs[10] = '{6'h08, 8'h12, 14, 0, 6'h08, 8'h12, 48'h8292_1288_60F9, 1, 1};

        stcp = 1'b0; shcp = 1'b0; ds = 1'b0; oe = 1'b0;
        sys_rst_n = 1'b1;
        #2 sys_rst_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge sys_clk);
        checkOutput("disp_on oe low", 48'(disp_on), 48'd1);

        for (int i = 0; i < 11; i++) applyStimulus(i);

        // Partial frame, then asynchronous reset between clock edges
        for (int b = 0; b < 5; b++) sendBit(b[0]);
        @(negedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1 checkAllZero("mid-frame reset");
        oe = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge sys_clk);
        checkOutput("disp_on oe high", 48'(disp_on), 48'd0);
        oe = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge sys_clk);
        checkOutput("disp_on oe low again", 48'(disp_on), 48'd1);

        sendFrame(6'h20, 8'h55, 14, 0, lat, pulses);
        checkOutput("post-reset sel_out", 48'(sel_out), 48'h20);
        checkOutput("post-reset seg_out", 48'(seg_out), 48'h55);
        checkOutput("post-reset digit_seg", digit_seg, 48'h5500_0000_0000);
        checkOutput("post-reset frame_err", 48'(frame_err), 48'd0);
        checkOutput("post-reset onehot_err", 48'(onehot_err), 48'd0);
        checkOutput("post-reset valid_pulses", 48'(pulses), 48'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
